// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART packet controller: FSM encodings,
// destination codes and the reply-header byte selector.
package uart_pkt_pkg;

   localparam logic [7:0] DEST_READ    = 8'h00;
   localparam logic [7:0] DEST_WRITE   = 8'h01;
   localparam logic [7:0] DEFAULT_SYNC = 8'h55;
   localparam logic [2:0] HDR_BYTES    = 3'd5;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_DEST,
      ST_SRC,
      ST_LEN,
      ST_ADDR,
      ST_WDATA,
      ST_RD_FETCH,
      ST_RD_WAIT,
      ST_RD_SAMPLE,
      ST_TX_WAIT
   } pktState_t;

   typedef enum logic [1:0] {
      TXS_IDLE,
      TXS_SEND,
      TXS_WAIT_HI,
      TXS_WAIT_LO
   } txSeqState_t;

   // Reply header order: SYNC, requester (Source), own address, Length, Address.
   function automatic logic [7:0] replyHeader(
      input logic [2:0] idx,
      input logic [7:0] syncByte,
      input logic [7:0] srcByte,
      input logic [7:0] ownByte,
      input logic [7:0] lenByte,
      input logic [7:0] addrByte
   );
      logic [7:0] hdr;
      hdr = 8'h00;
      case (idx)
         3'd0:    hdr = syncByte;
         3'd1:    hdr = srcByte;
         3'd2:    hdr = ownByte;
         3'd3:    hdr = lenByte;
         3'd4:    hdr = addrByte;
         default: hdr = 8'h00;
      endcase
      return hdr;
   endfunction

endpackage

// File: rtl/uart_pkt_tx_seq.sv
// Single-byte transmit handshake: wait for an idle transmitter, pulse send,
// then see busy rise and fall before reporting done.
module uart_pkt_tx_seq
   import uart_pkt_pkg::*;
(
   input  logic       ipClk,
   input  logic       ipReset,
   input  logic [7:0] ipByte,
   input  logic       ipStart,
   input  logic       ipTxBusy,
   output logic [7:0] opTxData,
   output logic       opTxSend,
   output logic       opDone
);

   txSeqState_t state;

   always_ff @(posedge ipClk or negedge ipReset) begin
      if (!ipReset) begin
         state    <= TXS_IDLE;
         opTxData <= 8'h00;
         opTxSend <= 1'b0;
         opDone   <= 1'b0;
      end else begin
         opTxSend <= 1'b0;
         opDone   <= 1'b0;
         case (state)
            TXS_IDLE: begin
               if (ipStart) begin
                  opTxData <= ipByte;
                  state    <= TXS_SEND;
               end
            end
            TXS_SEND: begin
               if (!ipTxBusy) begin
                  opTxSend <= 1'b1;
                  state    <= TXS_WAIT_HI;
               end
            end
            TXS_WAIT_HI: begin
               if (ipTxBusy) state <= TXS_WAIT_LO;
            end
            TXS_WAIT_LO: begin
               if (!ipTxBusy) begin
                  opDone <= 1'b1;
                  state  <= TXS_IDLE;
               end
            end
            default: state <= TXS_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_packet_ctrl.sv
// UART packet controller: parses SYNC/DEST/SRC/LEN/ADDR packets into register
// writes or read replies. Define UART_PKT_TIMEOUT_EN to enable the inter-byte timeout.
module uart_packet_ctrl
   import uart_pkt_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC,
   parameter logic [7:0] OWN_ADDR       = 8'h00,
   parameter int         TIMEOUT_CYCLES = 50000
) (
   input  logic       ipClk,
   input  logic       ipReset,
   input  logic [7:0] ipRxData,
   input  logic       ipRxValid,
   output logic [7:0] opTxData,
   output logic       opTxSend,
   input  logic       ipTxBusy,
   output logic [7:0] opRegAddress,
   output logic [7:0] opRegWrData,
   output logic       opRegWrEnable,
   input  logic [7:0] ipRegRdData,
   output logic       opBusy,
   output logic       opError
);

   pktState_t  state;
   logic       isWrite;
   logic [7:0] srcReg;
   logic [7:0] lenReg;
   logic [7:0] addrReg;
   logic [7:0] curAddr;
   logic [7:0] count;
   logic [2:0] hdrIdx;
   logic [7:0] txByte;
   logic       txStart;
   logic       txDone;
   logic       rxTimeout;

`ifdef UART_PKT_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] toCnt;
   logic            inRecv;

   assign inRecv    = (state == ST_DEST) || (state == ST_SRC) || (state == ST_LEN) ||
                      (state == ST_ADDR) || (state == ST_WDATA);
   assign rxTimeout = inRecv && !ipRxValid && (toCnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge ipClk or negedge ipReset) begin
      if (!ipReset) begin
         toCnt <= '0;
      end else if (!inRecv || ipRxValid || rxTimeout) begin
         toCnt <= '0;
      end else begin
         toCnt <= toCnt + TO_W'(1);
      end
   end
`else
   logic unusedTimeoutCfg;

   assign unusedTimeoutCfg = ^TIMEOUT_CYCLES;
   assign rxTimeout        = 1'b0;
`endif

   assign opBusy = (state != ST_IDLE);

   always_ff @(posedge ipClk or negedge ipReset) begin
      if (!ipReset) begin
         state         <= ST_IDLE;
         isWrite       <= 1'b0;
         srcReg        <= 8'h00;
         lenReg        <= 8'h00;
         addrReg       <= 8'h00;
         curAddr       <= 8'h00;
         count         <= 8'h00;
         hdrIdx        <= 3'd0;
         txByte        <= 8'h00;
         txStart       <= 1'b0;
         opRegAddress  <= 8'h00;
         opRegWrData   <= 8'h00;
         opRegWrEnable <= 1'b0;
         opError       <= 1'b0;
      end else begin
         opRegWrEnable <= 1'b0;
         opError       <= 1'b0;
         txStart       <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (ipRxValid && (ipRxData == SYNC_BYTE)) state <= ST_DEST;
            end
            ST_DEST: begin
               if (ipRxValid) begin
                  if (ipRxData == DEST_WRITE) begin
                     isWrite <= 1'b1;
                     state   <= ST_SRC;
                  end else if (ipRxData == DEST_READ) begin
                     isWrite <= 1'b0;
                     state   <= ST_SRC;
                  end else begin
                     opError <= 1'b1;
                     state   <= ST_IDLE;
                  end
               end
            end
            ST_SRC: begin
               if (ipRxValid) begin
                  srcReg <= ipRxData;
                  state  <= ST_LEN;
               end
            end
            ST_LEN: begin
               if (ipRxValid) begin
                  lenReg <= ipRxData;
                  count  <= ipRxData;
                  state  <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (ipRxValid) begin
                  addrReg <= ipRxData;
                  curAddr <= ipRxData;
                  if (isWrite) begin
                     state <= (count == 8'h00) ? ST_IDLE : ST_WDATA;
                  end else begin
                     hdrIdx <= 3'd0;
                     state  <= ST_RD_FETCH;
                  end
               end
            end
            ST_WDATA: begin
               if (ipRxValid) begin
                  opRegAddress  <= curAddr;
                  opRegWrData   <= ipRxData;
                  opRegWrEnable <= 1'b1;
                  curAddr       <= curAddr + 8'd1;
                  count         <= count - 8'd1;
                  if (count == 8'd1) state <= ST_IDLE;
               end
            end
            // Reply dispatcher: header bytes first, then one fetch per data byte.
            ST_RD_FETCH: begin
               if (hdrIdx != HDR_BYTES) begin
                  txByte  <= replyHeader(hdrIdx, SYNC_BYTE, srcReg, OWN_ADDR, lenReg, addrReg);
                  txStart <= 1'b1;
                  hdrIdx  <= hdrIdx + 3'd1;
                  state   <= ST_TX_WAIT;
               end else if (count == 8'h00) begin
                  state <= ST_IDLE;
               end else begin
                  opRegAddress <= curAddr;
                  state        <= ST_RD_WAIT;
               end
            end
            ST_RD_WAIT: begin
               state <= ST_RD_SAMPLE;
            end
            ST_RD_SAMPLE: begin
               txByte  <= ipRegRdData;
               txStart <= 1'b1;
               curAddr <= curAddr + 8'd1;
               count   <= count - 8'd1;
               state   <= ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
               if (txDone) state <= ST_RD_FETCH;
            end
            default: state <= ST_IDLE;
         endcase
         if (rxTimeout) begin
            opError <= 1'b1;
            state   <= ST_IDLE;
         end
      end
   end

   uart_pkt_tx_seq uTxSeq (
      .ipClk    (ipClk),
      .ipReset  (ipReset),
      .ipByte   (txByte),
      .ipStart  (txStart),
      .ipTxBusy (ipTxBusy),
      .opTxData (opTxData),
      .opTxSend (opTxSend),
      .opDone   (txDone)
   );

endmodule

// File: tb/tb_uart_packet_ctrl.sv
// Scoreboard bench for uart_packet_ctrl: directed packets push expected writes,
// reply bytes and error pulses; a negedge monitor pops and compares.
module tb_uart_packet_ctrl;

   typedef logic [7:0] byteQ_t[$];

   logic       ipClk = 1'b0;
   logic       ipReset;
   logic [7:0] ipRxData;
   logic       ipRxValid;
   logic [7:0] opTxData;
   logic       opTxSend;
   logic       ipTxBusy;
   logic [7:0] opRegAddress;
   logic [7:0] opRegWrData;
   logic       opRegWrEnable;
   logic [7:0] ipRegRdData;
   logic       opBusy;
   logic       opError;

   int          checks = 0;
   int          errors = 0;
   int          errExp = 0;
   int          busyCnt = 0;
   logic        busySeen = 1'b1;
   logic [15:0] wrQ[$];
   logic [7:0]  txQ[$];
   logic [7:0]  mem[256];

   always #5 ipClk = ~ipClk;

   uart_packet_ctrl #(
      .SYNC_BYTE      (8'h55),
      .OWN_ADDR       (8'h00),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .ipClk         (ipClk),
      .ipReset       (ipReset),
      .ipRxData      (ipRxData),
      .ipRxValid     (ipRxValid),
      .opTxData      (opTxData),
      .opTxSend      (opTxSend),
      .ipTxBusy      (ipTxBusy),
      .opRegAddress  (opRegAddress),
      .opRegWrData   (opRegWrData),
      .opRegWrEnable (opRegWrEnable),
      .ipRegRdData   (ipRegRdData),
      .opBusy        (opBusy),
      .opError       (opError)
   );

   // UART transmitter model: busy for four cycles after each send.
   always @(posedge ipClk) begin
      if (opTxSend) busyCnt <= 4;
      else if (busyCnt > 0) busyCnt <= busyCnt - 1;
   end
   assign ipTxBusy = (busyCnt != 0);

   // Register file model with registered read.
   always @(posedge ipClk) ipRegRdData <= mem[opRegAddress];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [15:0] act);
      checks++;
      errors++;
      $display("FAIL %s: unexpected event, value %0h, expected none", name, act);
   endtask

   always @(negedge ipClk) begin
      if (ipReset) begin
         if (opRegWrEnable && opTxSend) unexpected("wr_tx_overlap", {opRegAddress, opTxData});
         if (opRegWrEnable) begin
            $display("wr addr=%02h data=%02h", opRegAddress, opRegWrData);
            mem[opRegAddress] = opRegWrData;
            if (wrQ.size() == 0) unexpected("wr_extra", {opRegAddress, opRegWrData});
            else check("wr", {opRegAddress, opRegWrData}, wrQ.pop_front());
         end
         if (opTxSend) begin
            $display("tx byte=%02h", opTxData);
            check("tx_busy_low", {15'd0, ipTxBusy}, 16'd0);
            check("tx_busy_cycled", {15'd0, busySeen}, 16'd1);
            busySeen = 1'b0;
            if (txQ.size() == 0) unexpected("tx_extra", {8'd0, opTxData});
            else check("tx", {8'd0, opTxData}, {8'd0, txQ.pop_front()});
         end
         if (ipTxBusy) busySeen = 1'b1;
         if (opError) begin
            $display("error pulse");
            if (errExp == 0) unexpected("err_extra", 16'd1);
            else begin
               checks++;
               errExp--;
            end
         end
      end
   end

   task automatic sendByte(input logic [7:0] b);
      @(posedge ipClk); #1;
      ipRxData  = b;
      ipRxValid = 1'b1;
      @(posedge ipClk); #1;
      ipRxValid = 1'b0;
   endtask

   task automatic sendPkt(input byteQ_t q);
      foreach (q[i]) sendByte(q[i]);
   endtask

   task automatic pushTx(input byteQ_t q);
      foreach (q[i]) txQ.push_back(q[i]);
   endtask

   task automatic waitIdle(input string name, input int budget);
      int n = 0;
      while (opBusy && n < budget) begin
         @(posedge ipClk); #1;
         n++;
      end
      check(name, {15'd0, opBusy}, 16'd0);
   endtask

   task automatic checkResetOutputs(input string tag);
      check({tag, "_txdata"}, {8'd0, opTxData}, 16'd0);
      check({tag, "_txsend"}, {15'd0, opTxSend}, 16'd0);
      check({tag, "_regaddr"}, {8'd0, opRegAddress}, 16'd0);
      check({tag, "_wrdata"}, {8'd0, opRegWrData}, 16'd0);
      check({tag, "_wren"}, {15'd0, opRegWrEnable}, 16'd0);
      check({tag, "_busy"}, {15'd0, opBusy}, 16'd0);
      check({tag, "_error"}, {15'd0, opError}, 16'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      byteQ_t pkt;
      ipReset   = 1'b0;
      ipRxData  = 8'h00;
      ipRxValid = 1'b0;
      repeat (3) @(posedge ipClk);
      #1;
      checkResetOutputs("rst");
      @(negedge ipClk);
      ipReset = 1'b1;
      repeat (2) @(posedge ipClk);

      // Four-byte write at 02..05.
      wrQ.push_back(16'h0203); wrQ.push_back(16'h0304);
      wrQ.push_back(16'h0405); wrQ.push_back(16'h0506);
      pkt = '{8'h55, 8'h01, 8'hAA, 8'h04, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      sendPkt(pkt);
      waitIdle("busy_after_wr4", 20);

      // Two-byte read of 02..03; bytes arriving mid-reply must be ignored.
      pkt = '{8'h55, 8'hAA, 8'h00, 8'h02, 8'h02, 8'h03, 8'h04};
      pushTx(pkt);
      pkt = '{8'h55, 8'h00, 8'hAA, 8'h02, 8'h02};
      sendPkt(pkt);
      sendByte(8'h55);
      sendByte(8'h01);
      waitIdle("busy_after_rd2", 500);

      // Write with address wrap FF -> 00.
      wrQ.push_back(16'hFF11); wrQ.push_back(16'h0022);
      pkt = '{8'h55, 8'h01, 8'hAA, 8'h02, 8'hFF, 8'h11, 8'h22};
      sendPkt(pkt);
      waitIdle("busy_after_wrwrap", 20);

      // Read with address wrap.
      pkt = '{8'h55, 8'hAA, 8'h00, 8'h02, 8'hFF, 8'h11, 8'h22};
      pushTx(pkt);
      pkt = '{8'h55, 8'h00, 8'hAA, 8'h02, 8'hFF};
      sendPkt(pkt);
      waitIdle("busy_after_rdwrap", 500);

      // Zero-length write and read.
      pkt = '{8'h55, 8'h01, 8'hAA, 8'h00, 8'h30};
      sendPkt(pkt);
      waitIdle("busy_after_wr0", 20);
      pkt = '{8'h55, 8'hAA, 8'h00, 8'h00, 8'h7E};
      pushTx(pkt);
      pkt = '{8'h55, 8'h00, 8'hAA, 8'h00, 8'h7E};
      sendPkt(pkt);
      waitIdle("busy_after_rd0", 300);

      // Junk bytes, then a bad destination, then a good packet.
      sendByte(8'h12);
      sendByte(8'h34);
      check("busy_after_junk", {15'd0, opBusy}, 16'd0);
      sendByte(8'h55);
      errExp = 1;
      sendByte(8'h07);
      repeat (3) @(posedge ipClk);
      #1;
      check("err_seen_baddest", 16'(errExp), 16'd0);
      check("busy_after_baddest", {15'd0, opBusy}, 16'd0);
      wrQ.push_back(16'h4077);
      pkt = '{8'h55, 8'h01, 8'hAA, 8'h01, 8'h40, 8'h77};
      sendPkt(pkt);
      waitIdle("busy_after_recover", 20);

      // Reset after the third data byte of a four-byte write.
      wrQ.push_back(16'h10A1); wrQ.push_back(16'h11A2); wrQ.push_back(16'h12A3);
      pkt = '{8'h55, 8'h01, 8'hAA, 8'h04, 8'h10, 8'hA1, 8'hA2, 8'hA3};
      sendPkt(pkt);
      @(negedge ipClk); #1;
      ipReset = 1'b0;
      #1;
      checkResetOutputs("rst_mid");
      repeat (3) @(posedge ipClk);
      @(negedge ipClk);
      ipReset = 1'b1;
      sendByte(8'hA4);
      repeat (2) @(posedge ipClk);
      #1;
      check("busy_after_abort", {15'd0, opBusy}, 16'd0);
      wrQ.push_back(16'h205A);
      pkt = '{8'h55, 8'h01, 8'hAA, 8'h01, 8'h20, 8'h5A};
      sendPkt(pkt);
      waitIdle("busy_after_reset_pkt", 20);

`ifdef UART_PKT_TIMEOUT_EN
      // Stall after the destination byte until the inter-byte timeout fires.
      errExp = 1;
      sendByte(8'h55);
      sendByte(8'h01);
      repeat (50) @(posedge ipClk);
      #1;
      check("busy_during_stall", {15'd0, opBusy}, 16'd1);
      repeat (60) @(posedge ipClk);
      #1;
      check("busy_after_timeout", {15'd0, opBusy}, 16'd0);
      check("err_seen_timeout", 16'(errExp), 16'd0);
`endif

      repeat (10) @(posedge ipClk);
      #1;
      check("wr_pending", 16'(wrQ.size()), 16'd0);
      check("tx_pending", 16'(txQ.size()), 16'd0);
      check("err_pending", 16'(errExp), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
